// File: rtl/inv_pkg.sv
// Shared definitions for the find_inv_* controller family: the controller
// state encoding and the bvneg/bvule predicate used to validate candidates.
package inv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_SEARCH = 2'd2,
        ST_RESP   = 2'd3
    } ctrl_state_e;

    // Unsigned test (-x mod 2^w) <= t on the low w bits of x and t.
    // Operands are carried at 32 bits so any controller up to w=32 can call it.
    function automatic logic bvneg_ule(input logic [31:0] x,
                                       input logic [31:0] t,
                                       input int unsigned w);
        logic [31:0] mask;
        logic [31:0] neg;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        neg  = (~x + 32'd1) & mask;
        return (neg <= (t & mask));
    endfunction

endpackage

// File: rtl/bvneg_ule_check.sv
// Combinational W-bit evaluator for P(x,t) = (-x mod 2^W) <=u t.
// A single instance serves both the first check and every search step,
// since the controller only looks at one candidate per cycle.
module bvneg_ule_check
    import inv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_t,
    output logic         o_ok
);

    assign o_ok = bvneg_ule(32'(i_x), 32'(i_t), W);

endmodule

// File: rtl/inv_bvule_bvneg_ctrl.sv
// Checker/fallback sequencer for the bvule/bvneg inverse. A candidate from
// the Skolem function is accepted as-is when it satisfies -x <=u t; otherwise
// the controller walks forward from candidate+1 (wrapping) and returns the
// first satisfying value. x=0 always satisfies, so the walk is bounded by
// 2^W-1 steps and the iteration counter fits in W bits.
module inv_bvule_bvneg_ctrl
    import inv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_t,
    input  logic [W-1:0] req_cand,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_x,
    output logic         rsp_cand_ok,
    output logic [W-1:0] rsp_iters,
    output logic         busy
);

    ctrl_state_e  r_state;
    logic [W-1:0] r_tQ;
    logic [W-1:0] r_cur;
    logic [W-1:0] r_xQ;
    logic [W-1:0] r_iters;
    logic         r_okQ;
    logic         w_pass;

    bvneg_ule_check #(.W(W)) u_check (
        .i_x  (r_cur),
        .i_t  (r_tQ),
        .o_ok (w_pass)
    );

    // Controller FSM plus the target, cursor, result and iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tQ    <= '0;
            r_cur   <= '0;
            r_xQ    <= '0;
            r_iters <= '0;
            r_okQ   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_tQ    <= req_t;
                        r_cur   <= req_cand;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_iters <= '0;
                    if (w_pass) begin
                        r_xQ    <= r_cur;
                        r_okQ   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_okQ   <= 1'b0;
                        r_cur   <= r_cur + W'(1);
                        r_state <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    r_iters <= r_iters + W'(1);
                    if (w_pass) begin
                        r_xQ    <= r_cur;
                        r_state <= ST_RESP;
                    end else begin
                        r_cur   <= r_cur + W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign busy        = (r_state != ST_IDLE);
    assign rsp_x       = r_xQ;
    assign rsp_cand_ok = r_okQ;
    assign rsp_iters   = r_iters;

endmodule

// File: tb/tb_inv_bvule_bvneg_ctrl.sv
// Testbench for inv_bvule_bvneg_ctrl at W=4: table-driven vectors, hand-written
// backpressure and reset-abort sequences, and a sweep of every (t,cand) pair.
// Expected responses are queued when a request is driven and popped when the
// DUT presents its response.
module tb_inv_bvule_bvneg_ctrl;

    typedef struct {
        logic [3:0] t;
        logic [3:0] cand;
        logic [3:0] x;
        logic       ok;
        logic [3:0] iters;
        int         lat;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_t;
    logic [3:0] req_cand;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_x;
    logic       rsp_cand_ok;
    logic [3:0] rsp_iters;
    logic       busy;

    int   total;
    int   bad;
    vec_t sb[$];
    vec_t table_v[8];

    inv_bvule_bvneg_ctrl #(.W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_t       (req_t),
        .req_cand    (req_cand),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_x       (rsp_x),
        .rsp_cand_ok (rsp_cand_ok),
        .rsp_iters   (rsp_iters),
        .busy        (busy)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference predicate written arithmetically: -x mod 16 as (16-x)%16
    function automatic bit modelP(input int x, input int t);
        int n;
        n = (16 - x) % 16;
        return (n <= t);
    endfunction

    // Expected response built from the reference predicate and a wrap-order walk
    function automatic vec_t makeExp(input int t, input int c);
        vec_t e;
        e.t = 4'(t);
        e.cand = 4'(c);
        if (modelP(c, t)) begin
            e.x = 4'(c); e.ok = 1'b1; e.iters = 4'd0; e.lat = 2;
        end else begin
            e.x = 4'd0; e.ok = 1'b0; e.iters = 4'd0; e.lat = 0;
            for (int k = 1; k <= 16; k++) begin
                if (e.lat == 0 && modelP((c + k) % 16, t)) begin
                    e.x = 4'((c + k) % 16); e.iters = 4'(k); e.lat = 2 + k;
                end
            end
        end
        return e;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Wait for req_ready, present one request, queue its expected response
    task automatic applyStimulus(input logic [3:0] t, input logic [3:0] c,
                                 input vec_t exp, output int waited);
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) checkVal("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_t     = t;
        req_cand  = c;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_t     = ~t;
        req_cand  = ~c;
    endtask

    // Wait for the response, compare against the queue head, optionally
    // stall it for hold cycles, then complete the handshake
    task automatic checkOutput(input int hold);
        int   lat;
        vec_t e;
        lat = 1;
        checkVal("busy_in_check", int'(busy), 1);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            checkVal("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            checkVal("rsp_timeout", 0, 1);
            return;
        end
        checkVal("rsp_x", int'(rsp_x), int'(e.x));
        checkVal("rsp_cand_ok", int'(rsp_cand_ok), int'(e.ok));
        checkVal("rsp_iters", int'(rsp_iters), int'(e.iters));
        checkVal("latency", lat, e.lat);
        checkVal("pred_holds", int'(modelP(int'(rsp_x), int'(e.t))), 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkVal("hold_valid", int'(rsp_valid), 1);
            checkVal("hold_x", int'(rsp_x), int'(e.x));
            checkVal("hold_req_ready", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkVal("post_valid", int'(rsp_valid), 0);
        checkVal("post_req_ready", int'(req_ready), 1);
    endtask

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   waited;
        bit   sawValid;
        vec_t e;

        total = 0;
        bad   = 0;
        table_v[0] = '{t: 4'd5,  cand: 4'd11, x: 4'd11, ok: 1'b1, iters: 4'd0,  lat: 2};
        table_v[1] = '{t: 4'd5,  cand: 4'd1,  x: 4'd11, ok: 1'b0, iters: 4'd10, lat: 12};
        table_v[2] = '{t: 4'd0,  cand: 4'd3,  x: 4'd0,  ok: 1'b0, iters: 4'd13, lat: 15};
        table_v[3] = '{t: 4'd15, cand: 4'd7,  x: 4'd7,  ok: 1'b1, iters: 4'd0,  lat: 2};
        table_v[4] = '{t: 4'd3,  cand: 4'd0,  x: 4'd0,  ok: 1'b1, iters: 4'd0,  lat: 2};
        table_v[5] = '{t: 4'd2,  cand: 4'd15, x: 4'd15, ok: 1'b1, iters: 4'd0,  lat: 2};
        table_v[6] = '{t: 4'd1,  cand: 4'd2,  x: 4'd15, ok: 1'b0, iters: 4'd13, lat: 15};
        table_v[7] = '{t: 4'd0,  cand: 4'd0,  x: 4'd0,  ok: 1'b1, iters: 4'd0,  lat: 2};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_t     = 4'd0;
        req_cand  = 4'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("rst_req_ready", int'(req_ready), 1);
        checkVal("rst_rsp_valid", int'(rsp_valid), 0);
        checkVal("rst_rsp_x", int'(rsp_x), 0);
        checkVal("rst_cand_ok", int'(rsp_cand_ok), 0);
        checkVal("rst_iters", int'(rsp_iters), 0);
        checkVal("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(table_v[i].t, table_v[i].cand, table_v[i], waited);
            checkOutput(0);
        end

        // Backpressure for 3 cycles, then a back-to-back request
        applyStimulus(4'd15, 4'd7, makeExp(15, 7), waited);
        checkOutput(3);
        applyStimulus(4'd5, 4'd11, makeExp(5, 11), waited);
        checkVal("b2b_accept_wait", waited, 0);
        checkOutput(0);

        // Asynchronous reset in the middle of a search
        applyStimulus(4'd0, 4'd1, makeExp(0, 1), waited);
        repeat (4) @(negedge clk);
        checkVal("pre_abort_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("abort_busy", int'(busy), 0);
        checkVal("abort_req_ready", int'(req_ready), 1);
        checkVal("abort_rsp_valid", int'(rsp_valid), 0);
        checkVal("abort_rsp_x", int'(rsp_x), 0);
        checkVal("abort_cand_ok", int'(rsp_cand_ok), 0);
        checkVal("abort_iters", int'(rsp_iters), 0);
        e = sb.pop_back();
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) sawValid = 1'b1;
        end
        checkVal("abort_no_rsp", int'(sawValid), 0);

        // Every (t,cand) pair with a random response stall
        for (int t = 0; t < 16; t++) begin
            for (int c = 0; c < 16; c++) begin
                applyStimulus(4'(t), 4'(c), makeExp(t, c), waited);
                checkOutput(int'($urandom_range(0, 1)));
            end
        end

        checkVal("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
